// File: rtl/cpu_pkg.sv
// Shared register-file types and sizes for the CPU datapath.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Decode sets a bit at issue, writeback clears it. A set and a clear of
// the same register in one cycle leaves it set, because the newer writer
// is still outstanding.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_en,
  input  reg_addr_t wb_rd,
  input  logic      iss_valid,
  input  logic      iss_wr,
  input  reg_addr_t iss_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  logic [NREG-1:0] r_pending;
  logic            w_set;
  logic            w_clr;

  assign w_set = iss_valid && iss_wr && (iss_rd != REG_ZERO);
  assign w_clr = wb_en && (wb_rd != REG_ZERO);

  // Pending vector update; the set is applied after the clear so it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      if (w_clr) r_pending[wb_rd]  <= 1'b0;
      if (w_set) r_pending[iss_rd] <= 1'b1;
    end
  end

  // Busy is masked in the writeback cycle because the read port bypasses.
  always_comb begin
    rs1_busy = r_pending[rs1_addr] && !(wb_en && (wb_rd == rs1_addr));
    rs2_busy = r_pending[rs2_addr] && !(wb_en && (wb_rd == rs2_addr));
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with two combinational read ports,
// same-cycle write-through bypass, hardwired x0, a pending-write
// scoreboard and a retire counter for committed register writes.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  reg_addr_t       wb_rd,
  input  word_t           wb_data,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output word_t           rs1_data,
  output word_t           rs2_data,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  reg_addr_t       iss_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [CNTW-1:0] wb_count
);

  word_t           r_regs [NREG];
  logic [CNTW-1:0] r_count;
  logic            w_commit;

  assign w_commit = wb_en && (wb_rd != REG_ZERO);
  assign wb_count = r_count;

  // Register array write; reset wins over an in-flight writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Retire counter of committed writes, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_commit) begin
      r_count <= r_count + CNTW'(1);
    end
  end

  // Read muxes: x0 reads zero, then writeback bypass, then the array.
  always_comb begin
    if (rs1_addr == REG_ZERO)                 rs1_data = '0;
    else if (wb_en && (wb_rd == rs1_addr))    rs1_data = wb_data;
    else                                      rs1_data = r_regs[rs1_addr];
    if (rs2_addr == REG_ZERO)                 rs2_data = '0;
    else if (wb_en && (wb_rd == rs2_addr))    rs2_data = wb_data;
    else                                      rs2_data = r_regs[rs2_addr];
  end

  regfile_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile with a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        iss_valid, iss_wr;
  logic [4:0]  iss_rd;
  logic        rs1_busy, rs2_busy;
  logic [31:0] wb_count;
  logic [31:0] rs1_data_n, rs2_data_n;
  logic        rs1_busy_n, rs2_busy_n;
  logic [3:0]  wb_count_n;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .wb_count(wb_count)
  );

  // Narrow-counter instance so the wrap of the retire counter is reachable.
  wb_regfile #(.CNTW(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data_n), .rs2_data(rs2_data_n),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n), .wb_count(wb_count_n)
  );

  typedef struct {
    int          id;
    logic [31:0] d1, d2;
    logic        b1, b2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          next_id = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    return m_pend[a] && !(wb_en && wb_rd == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
    m_cnt = 32'd0;
  endtask

  task automatic cmp(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL chk%0d %s got=%h exp=%h", id, nm, got, exp);
    end
  endtask

  // Monitor: outputs settle during the first half cycle and are sampled here.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.id, "rs1_data",   rs1_data,          e.d1);
      cmp(e.id, "rs2_data",   rs2_data,          e.d2);
      cmp(e.id, "rs1_busy",   {31'd0, rs1_busy}, {31'd0, e.b1});
      cmp(e.id, "rs2_busy",   {31'd0, rs2_busy}, {31'd0, e.b2});
      cmp(e.id, "wb_count",   wb_count,          e.cnt);
      cmp(e.id, "wb_count4",  {28'd0, wb_count_n}, {28'd0, e.cnt[3:0]});
      cmp(e.id, "rs1_data_n", rs1_data_n,        e.d1);
      cmp(e.id, "rs2_busy_n", {31'd0, rs2_busy_n}, {31'd0, e.b2});
    end
  end

  // One clock of stimulus: drive, push the expectation, then advance the model.
  task automatic cyc(input bit r, input bit we, input logic [4:0] rd, input logic [31:0] d,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input bit iv, input bit iw, input logic [4:0] ird);
    exp_t e;
    rst_n = r; wb_en = we; wb_rd = rd; wb_data = d;
    rs1_addr = a1; rs2_addr = a2; iss_valid = iv; iss_wr = iw; iss_rd = ird;
    #1;
    if (r) begin
      e.id = next_id++;
      e.d1 = m_read(a1); e.d2 = m_read(a2);
      e.b1 = m_busy(a1); e.b2 = m_busy(a2);
      e.cnt = m_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    if (!r) m_reset();
    else begin
      if (we && rd != 0) begin m_regs[rd] = d; m_pend[rd] = 1'b0; m_cnt = m_cnt + 1; end
      if (iv && iw && ird != 0) m_pend[ird] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1, 0, 0, 0, a1, a2, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    rst_n = 0; wb_en = 0; wb_rd = 0; wb_data = 0; rs1_addr = 0; rs2_addr = 0;
    iss_valid = 0; iss_wr = 0; iss_rd = 0;
    @(posedge clk); #1;

    // Reset for two cycles, then every address reads zero and idle
    cyc(0, 1, 5'd3, 32'h1234, 0, 0, 1, 1, 5'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) idle_read(5'(a), 5'(31 - a));

    // Write then read
    cyc(1, 1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd0, 0, 0, 0);
    idle_read(5'd5, 5'd5);
    // Bypass before the edge
    cyc(1, 1, 5'd7, 32'hDEADBEEF, 5'd5, 5'd7, 0, 0, 0);
    idle_read(5'd7, 5'd5);
    // x0 write dropped
    cyc(1, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 0, 0, 0);
    idle_read(5'd0, 5'd7);
    // Scoreboard set, visible busy, bypassed clear, then idle
    cyc(1, 0, 0, 0, 5'd3, 5'd0, 1, 1, 5'd3);
    idle_read(5'd3, 5'd3);
    cyc(1, 1, 5'd3, 32'h33333333, 5'd3, 5'd3, 0, 0, 0);
    idle_read(5'd3, 5'd3);
    // Set and clear collide: set wins
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 5'd4);
    cyc(1, 1, 5'd4, 32'h44444444, 5'd4, 5'd0, 1, 1, 5'd4);
    idle_read(5'd4, 5'd4);
    cyc(1, 1, 5'd4, 32'h44440000, 5'd4, 5'd4, 0, 0, 0);
    idle_read(5'd4, 5'd4);
    // Reset during writeback discards the write
    cyc(1, 1, 5'd9, 32'h99999999, 5'd9, 5'd0, 1, 1, 5'd10);
    cyc(0, 1, 5'd9, 32'h12345678, 5'd9, 5'd10, 0, 0, 0);
    idle_read(5'd9, 5'd10);

    // Randomized traffic honoring the no-WAW rule for issue
    for (int n = 0; n < 3000; n++) begin
      bit          r, we, iv, iw;
      logic [4:0]  rd, ird, a1, a2;
      r   = ($urandom_range(0, 199) != 0);
      we  = $urandom_range(0, 1);
      rd  = 5'($urandom_range(0, 7));
      iv  = $urandom_range(0, 1);
      iw  = $urandom_range(0, 3) != 0;
      ird = 5'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a2  = 5'($urandom_range(0, 7));
      if (m_pend[ird] && !(we && rd == ird)) iw = 0;
      cyc(r, we, rd, $urandom, a1, a2, iv, iw, ird);
    end

    // Drain the expectation queue with a bounded wait
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 pending expectations", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
